// File: rtl/vs_bus_scheduler.sv
// Shares the VS10xx SPI link between SCI register writes and SDI data bursts,
// paced on DREQ, with commands taking priority at transaction boundaries.
`timescale 1ns/1ps
module vs_bus_scheduler #(
  parameter int CLK_DIV      = 2,
  parameter int BURST_BYTES  = 32,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_DREQ,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_cmd_done,
  input  logic        i_dat_valid,
  input  logic [7:0]  i_dat_byte,
  output logic        o_dat_ready,
  output logic        o_XCS,
  output logic        o_XDCS,
  output logic        o_SCK,
  output logic        o_SI,
  output logic        o_busy
);

  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W      = $clog2(BURST_BYTES + 1);
  localparam int GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam int GRD_W      = (GUARD_LAST > 0) ? $clog2(GUARD_LAST + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD_SHIFT,
    CMD_GUARD,
    DAT_SHIFT,
    DAT_NEXT
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_dreqMeta;
  logic               r_dreqSync;
  logic [31:0]        r_shift;
  logic [4:0]         r_bitCnt;
  logic [DIV_W-1:0]   r_divCnt;
  logic               r_sck;
  logic [CNT_W-1:0]   r_burstCnt;
  logic [GRD_W-1:0]   r_guardCnt;
  logic               r_cmdDone;

  logic w_cmdReady;
  logic w_datReady;
  logic w_cmdAccept;
  logic w_datAccept;
  logic w_sckToggle;
  logic w_sckFall;
  logic w_lastBit;
  logic w_shiftDone;
  logic w_guardDone;
  logic w_burstRoom;

  assign w_cmdAccept = w_cmdReady & i_cmd_valid;
  assign w_datAccept = w_datReady & i_dat_valid;
  assign w_sckToggle = (r_divCnt == DIV_W'(CLK_DIV - 1));
  assign w_sckFall   = w_sckToggle & r_sck;
  assign w_lastBit   = (r_state == CMD_SHIFT) ? (r_bitCnt == 5'd31) : (r_bitCnt == 5'd7);
  assign w_shiftDone = w_sckFall & w_lastBit;
  assign w_guardDone = (r_guardCnt == GRD_W'(GUARD_LAST));
  assign w_burstRoom = (r_burstCnt < CNT_W'(BURST_BYTES));

  assign o_cmd_ready = w_cmdReady;
  assign o_dat_ready = w_datReady;
  assign o_cmd_done  = r_cmdDone;
  assign o_SCK       = r_sck;
  assign o_SI        = r_shift[31];
  assign o_busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmdAccept)      w_nextState = CMD_SHIFT;
        else if (w_datAccept) w_nextState = DAT_SHIFT;
      end
      CMD_SHIFT: if (w_shiftDone) w_nextState = CMD_GUARD;
      CMD_GUARD: if (w_guardDone) w_nextState = IDLE;
      DAT_SHIFT: if (w_shiftDone) w_nextState = DAT_NEXT;
      DAT_NEXT:  w_nextState = w_datAccept ? DAT_SHIFT : IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // XDCS stays low through DAT_NEXT only when the burst continues with another byte.
  always_comb begin
    w_cmdReady = 1'b0;
    w_datReady = 1'b0;
    o_XCS      = 1'b1;
    o_XDCS     = 1'b1;
    case (r_state)
      IDLE: begin
        w_cmdReady = r_dreqSync;
        w_datReady = r_dreqSync & ~i_cmd_valid;
      end
      CMD_SHIFT: o_XCS  = 1'b0;
      DAT_SHIFT: o_XDCS = 1'b0;
      DAT_NEXT: begin
        w_datReady = w_burstRoom & r_dreqSync;
        o_XDCS     = ~(w_datReady & i_dat_valid);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dreqMeta <= 1'b0;
      r_dreqSync <= 1'b0;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_divCnt   <= '0;
      r_sck      <= 1'b0;
      r_burstCnt <= '0;
      r_guardCnt <= '0;
      r_cmdDone  <= 1'b0;
    end else begin
      r_dreqMeta <= i_DREQ;
      r_dreqSync <= r_dreqMeta;
      r_cmdDone  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cmdAccept) begin
            r_shift  <= {8'h02, i_cmd_addr, i_cmd_data};
            r_bitCnt <= '0;
            r_divCnt <= '0;
            r_sck    <= 1'b0;
          end else if (w_datAccept) begin
            r_shift    <= {i_dat_byte, 24'h0};
            r_bitCnt   <= '0;
            r_divCnt   <= '0;
            r_sck      <= 1'b0;
            r_burstCnt <= '0;
          end
        end
        // Each SCK fall moves to the next bit; the final fall closes the frame.
        CMD_SHIFT, DAT_SHIFT: begin
          if (w_sckToggle) begin
            r_divCnt <= '0;
            r_sck    <= ~r_sck;
            if (r_sck) begin
              r_shift  <= {r_shift[30:0], 1'b0};
              r_bitCnt <= r_bitCnt + 5'd1;
            end
            if (w_shiftDone) begin
              if (r_state == CMD_SHIFT) begin
                r_cmdDone  <= 1'b1;
                r_guardCnt <= '0;
              end else if (w_burstRoom) begin
                r_burstCnt <= r_burstCnt + 1'b1;
              end
            end
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end
        CMD_GUARD: r_guardCnt <= r_guardCnt + 1'b1;
        DAT_NEXT: begin
          if (w_datAccept) begin
            r_shift  <= {i_dat_byte, 24'h0};
            r_bitCnt <= '0;
            r_divCnt <= '0;
            r_sck    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vs_bus_scheduler.sv
// Directed bench for vs_bus_scheduler: reset, SCI framing, SDI bursts,
// DREQ gating, arbitration and reset abort, checked by immediate assertions.
`timescale 1ns/1ps
module tb_vs_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_DREQ;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd_addr;
  logic [15:0] i_cmd_data;
  logic        o_cmd_ready;
  logic        o_cmd_done;
  logic        i_dat_valid;
  logic [7:0]  i_dat_byte;
  logic        o_dat_ready;
  logic        o_XCS;
  logic        o_XDCS;
  logic        o_SCK;
  logic        o_SI;
  logic        o_busy;

  always #5 clk = ~clk;

  vs_bus_scheduler #(.CLK_DIV(2), .BURST_BYTES(4), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .i_DREQ(i_DREQ),
    .i_cmd_valid(i_cmd_valid), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .o_cmd_done(o_cmd_done),
    .i_dat_valid(i_dat_valid), .i_dat_byte(i_dat_byte), .o_dat_ready(o_dat_ready),
    .o_XCS(o_XCS), .o_XDCS(o_XDCS), .o_SCK(o_SCK), .o_SI(o_SI), .o_busy(o_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Bus observer: decodes frames from SI at SCK rises and measures chip-select runs.
  int          cycle        = 0;
  logic        prevXcs      = 1'b1;
  logic        prevXdcs     = 1'b1;
  logic        prevSck      = 1'b0;
  int          xcsRun       = 0;
  int          lastXcsRun   = 0;
  int          xcsFallCycle = 0;
  logic [31:0] cmdBits      = '0;
  int          cmdBitCnt    = 0;
  int          xdcsRun      = 0;
  int          xdcsRuns     = 0;
  int          xdcsRunLog [0:31];
  int          xdcsRiseCycle = 0;
  logic [7:0]  datShift     = '0;
  int          datBitCnt    = 0;
  int          datCount     = 0;
  logic [7:0]  datLog [0:63];
  int          doneCnt      = 0;
  int          overlap      = 0;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (!o_XCS) begin
      if (prevXcs) begin
        xcsRun       <= 1;
        cmdBits      <= '0;
        cmdBitCnt    <= 0;
        xcsFallCycle <= cycle;
      end else begin
        xcsRun <= xcsRun + 1;
      end
    end else if (!prevXcs) begin
      lastXcsRun <= xcsRun;
    end
    if (!o_XDCS) begin
      if (prevXdcs) begin
        xdcsRun   <= 1;
        datBitCnt <= 0;
      end else begin
        xdcsRun <= xdcsRun + 1;
      end
    end else if (!prevXdcs) begin
      if (xdcsRuns < 32) xdcsRunLog[xdcsRuns] <= xdcsRun;
      xdcsRuns      <= xdcsRuns + 1;
      xdcsRiseCycle <= cycle;
    end
    if (o_SCK && !prevSck) begin
      if (!o_XCS) begin
        cmdBits   <= {cmdBits[30:0], o_SI};
        cmdBitCnt <= cmdBitCnt + 1;
      end
      if (!o_XDCS) begin
        datShift <= {datShift[6:0], o_SI};
        if (datBitCnt == 7) begin
          if (datCount < 64) datLog[datCount] <= {datShift[6:0], o_SI};
          datCount  <= datCount + 1;
          datBitCnt <= 0;
        end else begin
          datBitCnt <= datBitCnt + 1;
        end
      end
    end
    if (o_cmd_done) doneCnt <= doneCnt + 1;
    if (!o_XCS && !o_XDCS) overlap <= overlap + 1;
    prevXcs  <= o_XCS;
    prevXdcs <= o_XDCS;
    prevSck  <= o_SCK;
  end

  logic [7:0] txBytes [0:7];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Streams txBytes[0..n-1] through the valid/ready handshake; raises i_cmd_valid
  // once byte index cmdAt has been reached.
  task automatic applyStimulus(input int n, input int cmdAt, output bit ok);
    int idx;
    bit adv;
    idx = 0;
    i_dat_byte  = txBytes[0];
    i_dat_valid = 1'b1;
    for (int c = 0; c < 2000 && idx < n; c++) begin
      #1;
      adv = o_dat_ready;
      @(negedge clk);
      if (adv) begin
        idx++;
        if (idx == cmdAt) i_cmd_valid = 1'b1;
        if (idx < n) i_dat_byte = txBytes[idx];
        else         i_dat_valid = 1'b0;
      end
    end
    ok = (idx == n);
  endtask

  task automatic waitCmdAccept(output bit ok);
    bit acc;
    ok = 1'b0;
    i_cmd_valid = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      #1;
      acc = o_cmd_ready;
      @(negedge clk);
      if (acc) begin
        i_cmd_valid = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic waitCmdDone(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (o_cmd_done) ok = 1'b1;
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (!o_busy) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    bit acc;
    int runsBefore;
    int bytesBefore;
    int doneBefore;

    rst = 1'b1; i_DREQ = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_addr = 8'h00; i_cmd_data = 16'h0000;
    i_dat_valid = 1'b0; i_dat_byte = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_xcs", o_XCS, 1);
    checkOutput("rst_xdcs", o_XDCS, 1);
    checkOutput("rst_sck", o_SCK, 0);
    checkOutput("rst_si", o_SI, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_cmd_done", o_cmd_done, 0);
    checkOutput("rst_cmd_ready", o_cmd_ready, 0);
    checkOutput("rst_dat_ready", o_dat_ready, 0);
    rst = 1'b0;

    // DREQ low blocks everything; DREQ rise starts the command 3 cycles later.
    i_cmd_addr = 8'h0B; i_cmd_data = 16'hFCFC; i_cmd_valid = 1'b1;
    i_dat_byte = 8'h5A; i_dat_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("gate_cmd_ready", o_cmd_ready, 0);
    checkOutput("gate_dat_ready", o_dat_ready, 0);
    checkOutput("gate_busy", o_busy, 0);
    i_DREQ = 1'b1;
    @(negedge clk); #1;
    checkOutput("gate_xcs_n1", o_XCS, 1);
    @(negedge clk); #1;
    checkOutput("gate_xcs_n2", o_XCS, 1);
    checkOutput("gate_cmd_ready_n2", o_cmd_ready, 1);
    checkOutput("gate_dat_ready_n2", o_dat_ready, 0);
    @(negedge clk); #1;
    checkOutput("gate_xcs_n3", o_XCS, 0);
    checkOutput("gate_xdcs_n3", o_XDCS, 1);
    checkOutput("gate_si_msb", o_SI, 0);
    i_cmd_valid = 1'b0; i_dat_valid = 1'b0;

    // SCI frame, single done pulse, then the guard window.
    runsBefore = xdcsRuns;
    doneBefore = doneCnt;
    waitCmdDone(ok);
    checkOutput("sci_done_seen", ok, 1);
    checkOutput("sci_xcs_high_at_done", o_XCS, 1);
    checkOutput("sci_frame", cmdBits, 32'h020BFCFC);
    checkOutput("sci_bitcount", cmdBitCnt, 32);
    checkOutput("sci_xcs_low_cycles", lastXcsRun, 128);
    checkOutput("sci_xdcs_untouched", xdcsRuns - runsBefore, 0);
    checkOutput("guard_g0_ready", o_cmd_ready, 0);
    for (int g = 1; g < 4; g++) begin
      @(negedge clk); #1;
      checkOutput("guard_ready", o_cmd_ready, 0);
      checkOutput("guard_busy", o_busy, 1);
    end
    checkOutput("sci_done_single", doneCnt - doneBefore, 1);
    @(negedge clk); #1;
    checkOutput("guard_over_ready", o_cmd_ready, 1);
    checkOutput("guard_over_busy", o_busy, 0);

    // Six bytes with BURST_BYTES=4 split into a 4-byte and a 2-byte burst.
    txBytes[0] = 8'hA5; txBytes[1] = 8'h5A; txBytes[2] = 8'h00;
    txBytes[3] = 8'hFF; txBytes[4] = 8'h3C; txBytes[5] = 8'hC3;
    runsBefore  = xdcsRuns;
    bytesBefore = datCount;
    applyStimulus(6, -1, ok);
    checkOutput("sdi_stream_timeout", ok, 1);
    waitIdle(ok);
    checkOutput("sdi_idle_timeout", ok, 1);
    checkOutput("sdi_burst_count", xdcsRuns - runsBefore, 2);
    checkOutput("sdi_burst1_len", xdcsRunLog[runsBefore], 131);
    checkOutput("sdi_burst2_len", xdcsRunLog[runsBefore + 1], 65);
    checkOutput("sdi_byte_count", datCount - bytesBefore, 6);
    for (int k = 0; k < 6; k++)
      checkOutput("sdi_byte", datLog[bytesBefore + k], txBytes[k]);

    // Command raised during byte 2 waits for the burst to finish.
    txBytes[0] = 8'h11; txBytes[1] = 8'h22; txBytes[2] = 8'h33; txBytes[3] = 8'h44;
    i_cmd_addr = 8'h03; i_cmd_data = 16'h1234;
    runsBefore  = xdcsRuns;
    bytesBefore = datCount;
    applyStimulus(4, 2, ok);
    checkOutput("arb_stream_timeout", ok, 1);
    checkOutput("arb_xcs_held_off", o_XCS, 1);
    waitCmdAccept(ok);
    checkOutput("arb_accept_timeout", ok, 1);
    waitCmdDone(ok);
    checkOutput("arb_done_seen", ok, 1);
    checkOutput("arb_burst_len", xdcsRunLog[runsBefore], 131);
    checkOutput("arb_burst_count", xdcsRuns - runsBefore, 1);
    checkOutput("arb_cmd_after_burst", xcsFallCycle - xdcsRiseCycle, 2);
    checkOutput("arb_frame", cmdBits, 32'h02031234);
    checkOutput("arb_xcs_low_cycles", lastXcsRun, 128);
    for (int k = 0; k < 4; k++)
      checkOutput("arb_byte", datLog[bytesBefore + k], txBytes[k]);

    // DREQ drop mid-byte: the byte finishes, then XDCS releases.
    runsBefore  = xdcsRuns;
    bytesBefore = datCount;
    i_dat_byte = 8'h81; i_dat_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      #1;
      acc = o_dat_ready;
      @(negedge clk);
      if (acc) ok = 1'b1;
    end
    checkOutput("drop_accept_timeout", ok, 1);
    #1;
    checkOutput("drop_xdcs_asserted", o_XDCS, 0);
    checkOutput("drop_si_msb", o_SI, 1);
    i_DREQ = 1'b0;
    waitIdle(ok);
    checkOutput("drop_idle_timeout", ok, 1);
    checkOutput("drop_burst_count", xdcsRuns - runsBefore, 1);
    checkOutput("drop_burst_len", xdcsRunLog[runsBefore], 32);
    checkOutput("drop_byte", datLog[bytesBefore], 8'h81);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("drop_dat_ready", o_dat_ready, 0);
    checkOutput("drop_busy", o_busy, 0);
    checkOutput("drop_byte_total", datCount - bytesBefore, 1);
    i_dat_valid = 1'b0;
    i_DREQ = 1'b1;

    // Reset after 10 SCK rises aborts the frame with no done pulse.
    i_cmd_addr = 8'h07; i_cmd_data = 16'hA55A;
    waitCmdAccept(ok);
    checkOutput("rstmid_accept_timeout", ok, 1);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (cmdBitCnt == 10) ok = 1'b1;
    end
    checkOutput("rstmid_rise_timeout", ok, 1);
    doneBefore = doneCnt;
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("rstmid_xcs", o_XCS, 1);
    checkOutput("rstmid_xdcs", o_XDCS, 1);
    checkOutput("rstmid_sck", o_SCK, 0);
    checkOutput("rstmid_si", o_SI, 0);
    checkOutput("rstmid_busy", o_busy, 0);
    checkOutput("rstmid_cmd_done", o_cmd_done, 0);
    checkOutput("rstmid_cmd_ready", o_cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("rstmid_discarded_busy", o_busy, 0);
    checkOutput("rstmid_discarded_xcs", o_XCS, 1);
    checkOutput("rstmid_no_done", doneCnt - doneBefore, 0);
    waitCmdAccept(ok);
    checkOutput("rstmid_reaccept_timeout", ok, 1);
    waitCmdDone(ok);
    checkOutput("rstmid_redone_seen", ok, 1);
    checkOutput("rstmid_frame", cmdBits, 32'h0207A55A);
    checkOutput("rstmid_bitcount", cmdBitCnt, 32);
    checkOutput("rstmid_xcs_low_cycles", lastXcsRun, 128);
    checkOutput("cs_never_both_low", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
